// File: rtl/ising_ctrl_pkg.sv
// Shared types and helpers for the oscillator-matrix run controller.
// Pair indexing maps an upper-triangle pair (i<j) onto the packed weight bus.
package ising_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned RST_CYCLES_DEFAULT = 4;

  function automatic int unsigned pair_count(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int unsigned pair_index(input int unsigned n, input int unsigned i,
                                             input int unsigned j);
    return n * i - i * (i + 1) / 2 + j - i - 1;
  endfunction

endpackage

// File: rtl/ising_sync2.sv
// Two-flop synchronizer for one asynchronous oscillator output.
module ising_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ising_run_ctrl.sv
// Anneal sequencer for the coupled-oscillator matrix: weight register, reset/run/sample
// phases and spin resolution. Optional abort input enabled by ISING_RUN_ABORT_EN.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned NUM_WEIGHTS = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SMP_W       = 8,
  parameter int unsigned RST_CYCLES  = RST_CYCLES_DEFAULT,
  localparam int unsigned NPAIR      = pair_count(N),
  localparam int unsigned PAIR_W     = ($clog2(NPAIR) > 1) ? $clog2(NPAIR) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [PAIR_W-1:0]            wr_addr,
  input  logic [NUM_WEIGHTS-1:0]       wr_data,
  input  logic                         start,
`ifdef ISING_RUN_ABORT_EN
  input  logic                         abort,
`endif
  input  logic [CNT_W-1:0]             run_cycles,
  input  logic [SMP_W-1:0]             sample_cycles,
  output logic [NUM_WEIGHTS*NPAIR-1:0] weights,
  output logic                         core_rstn,
  input  logic [N-1:0]                 osc_in,
  output logic                         busy,
  output logic                         done,
  output logic [N-1:0]                 spins
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   r_lat;
  logic [SMP_W-1:0]   s_lat;
  logic [N-1:0]       osc_sync;
  logic [SMP_W-1:0]   dis      [1:N-1];
  logic [SMP_W-1:0]   dis_nxt  [1:N-1];
  logic [N-1:0]       spins_nxt;
  logic               start_acc;

  for (genvar g = 0; g < N; g++) begin : g_sync
    ising_sync2 u_sync (
      .clk  (clk),
      .rst_n(rstn),
      .d    (osc_in[g]),
      .q    (osc_sync[g])
    );
  end

  assign wr_ready  = (state == IDLE);
  assign start_acc = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RESET;
      RESET:   if (cnt == CNT_W'(RST_CYCLES - 1))
                 state_next = (r_lat == '0) ? SAMPLE : RUN;
      RUN:     if (cnt == r_lat - CNT_W'(1)) state_next = SAMPLE;
      SAMPLE:  if (cnt == CNT_W'(s_lat) - CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef ISING_RUN_ABORT_EN
    if (abort && (state == RESET || state == RUN || state == SAMPLE)) state_next = IDLE;
`endif
  end

  // Disagreement counts including the current cycle, and the spin decision they imply
  always_comb begin
    spins_nxt = '0;
    for (int unsigned i = 1; i < N; i++) begin
      dis_nxt[i] = dis[i];
      if (state == SAMPLE && osc_sync[i] != osc_sync[0]) dis_nxt[i] = dis[i] + SMP_W'(1);
      spins_nxt[i] = (dis_nxt[i] > (s_lat >> 1));
    end
  end

  // Phase counter restarts on every state change
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (state != IDLE)       cnt <= cnt + CNT_W'(1);
  end

  // Run parameters, captured once per anneal; a zero sample window still samples once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lat <= '0;
      s_lat <= '0;
    end else if (start_acc) begin
      r_lat <= run_cycles;
      s_lat <= (sample_cycles == '0) ? SMP_W'(1) : sample_cycles;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 1; i < N; i++) dis[i] <= '0;
    end else if (start_acc) begin
      for (int unsigned i = 1; i < N; i++) dis[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < N; i++) dis[i] <= dis_nxt[i];
    end
  end

  // Weight register; out-of-range addresses match no pair and are dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weights <= '0;
    end else if (wr_valid && wr_ready) begin
      for (int unsigned k = 0; k < NPAIR; k++) begin
        if (wr_addr == PAIR_W'(k)) weights[k*NUM_WEIGHTS +: NUM_WEIGHTS] <= wr_data;
      end
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_rstn <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spins     <= '0;
    end else begin
      core_rstn <= (state_next == RUN) || (state_next == SAMPLE);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      if (state == SAMPLE && state_next == DONE) spins <= spins_nxt;
    end
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: weight-write table, anneal table, and
// hand sequences for same-cycle write/start and reset during sampling.
module tb_ising_run_ctrl;
  import ising_ctrl_pkg::*;

  localparam int unsigned N     = 3;
  localparam int unsigned NW    = 5;
  localparam int unsigned NPAIR = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0]      wr_addr = '0;
  logic [NW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic [15:0]     run_cycles = '0;
  logic [7:0]      sample_cycles = '0;
  logic [NW*NPAIR-1:0] weights;
  logic            core_rstn;
  logic [N-1:0]    osc_in = '0;
  logic            busy;
  logic            done;
  logic [N-1:0]    spins;

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;
  int mode  = 0;
  logic [N-1:0] last_spins = '0;

  ising_run_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .run_cycles   (run_cycles),
    .sample_cycles(sample_cycles),
    .weights      (weights),
    .core_rstn    (core_rstn),
    .osc_in       (osc_in),
    .busy         (busy),
    .done         (done),
    .spins        (spins)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   i;
    int unsigned   j;
    logic [1:0]    raw_addr;
    bit            use_raw;
    logic [NW-1:0] data;
    logic [14:0]   exp_w;
  } wr_vec_t;

  typedef struct {
    logic [15:0] run;
    logic [7:0]  samp;
    int          mode;
    int          lat;
    logic [2:0]  exp_spins;
    bit          restart;
  } run_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Oscillator patterns: 0 all agree, 1 osc1 inverted, 2 osc0 4-of-8 duty, 3 osc0 5-of-8 duty with osc2 following
  function automatic logic [N-1:0] osc_val(input int m, input int p);
    logic a;
    case (m)
      1:       osc_val = 3'b010;
      2:       begin a = ((p % 4) >= 2); osc_val = {1'b0, 1'b0, a}; end
      3:       begin a = ((p % 8) < 5);  osc_val = {a, 1'b0, a}; end
      default: osc_val = 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    phase  = phase + 1;
    osc_in = osc_val(mode, phase);
  endtask

  task automatic run_one(input run_vec_t v);
    int c, lo, hi, bad;
    bit seen;
    int unsigned s_eff;
    s_eff = (v.samp == 0) ? 1 : int'(v.samp);
    mode = v.mode;
    run_cycles = v.run;
    sample_cycles = v.samp;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles = 16'hFFFF;
    sample_cycles = 8'hFF;
    c = 0; lo = 0; hi = 0; bad = 0; seen = 0;
    check("spins_hold", 32'(spins), 32'(last_spins));
    while (c < 400) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (core_rstn) hi++; else lo++;
      if (!busy || wr_ready) bad++;
      start = (v.restart && c == 6);
      tick();
      c++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(c), 32'(v.lat));
    check("rst_low_cycles", 32'(lo), 32'd4);
    check("rst_high_cycles", 32'(hi), 32'(int'(v.run) + int'(s_eff)));
    check("busy_ready_run", 32'(bad), 32'd0);
    check("spins", 32'(spins), 32'(v.exp_spins));
    check("done_busy", 32'(busy), 32'd1);
    check("done_core_rstn", 32'(core_rstn), 32'd0);
    tick();
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(wr_ready), 32'd1);
    check("spins_after", 32'(spins), 32'(v.exp_spins));
    last_spins = v.exp_spins;
  endtask

  wr_vec_t  wv[5];
  run_vec_t rv[7];

  initial begin
    int c;
    bit seen;

    wv[0] = '{i: 0, j: 1, raw_addr: 2'd0, use_raw: 0, data: 5'h03, exp_w: 15'h0003};
    wv[1] = '{i: 1, j: 2, raw_addr: 2'd0, use_raw: 0, data: 5'h1F, exp_w: 15'h7C03};
    wv[2] = '{i: 0, j: 0, raw_addr: 2'd3, use_raw: 1, data: 5'h0A, exp_w: 15'h7C03};
    wv[3] = '{i: 0, j: 2, raw_addr: 2'd0, use_raw: 0, data: 5'h15, exp_w: 15'h7EA3};
    wv[4] = '{i: 0, j: 2, raw_addr: 2'd0, use_raw: 0, data: 5'h00, exp_w: 15'h7C03};

    rv[0] = '{run: 16'd10, samp: 8'd8, mode: 1, lat: 22, exp_spins: 3'b010, restart: 0};
    rv[1] = '{run: 16'd10, samp: 8'd8, mode: 2, lat: 22, exp_spins: 3'b000, restart: 0};
    rv[2] = '{run: 16'd3,  samp: 8'd8, mode: 3, lat: 15, exp_spins: 3'b010, restart: 0};
    rv[3] = '{run: 16'd0,  samp: 8'd0, mode: 1, lat: 5,  exp_spins: 3'b010, restart: 0};
    rv[4] = '{run: 16'd2,  samp: 8'd5, mode: 0, lat: 11, exp_spins: 3'b000, restart: 0};
    rv[5] = '{run: 16'd10, samp: 8'd8, mode: 1, lat: 22, exp_spins: 3'b010, restart: 1};
    rv[6] = '{run: 16'd0,  samp: 8'd3, mode: 1, lat: 7,  exp_spins: 3'b010, restart: 0};

    // Power-on reset values
    repeat (3) tick();
    check("rst_weights", 32'(weights), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spins", 32'(spins), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    rstn = 1'b1;
    tick();

    // Weight writes
    foreach (wv[k]) begin
      wr_valid = 1'b1;
      wr_addr  = wv[k].use_raw ? wv[k].raw_addr : 2'(pair_index(N, wv[k].i, wv[k].j));
      wr_data  = wv[k].data;
      check("wr_ready_idle", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      check("weights_wr", 32'(weights), 32'(wv[k].exp_w));
    end

    // Anneal runs
    foreach (rv[k]) run_one(rv[k]);

    // Write and start on the same edge; later write during the run is refused
    mode = 1;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 5'h11;
    run_cycles = 16'd0; sample_cycles = 8'd2; start = 1'b1;
    tick();
    wr_valid = 1'b0; start = 1'b0;
    check("same_cycle_weights", 32'(weights), 32'h7C11);
    check("same_cycle_core_rstn", 32'(core_rstn), 32'd0);
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 5'h1F;
    check("busy_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    check("busy_write_ignored", 32'(weights), 32'h7C11);
    c = 1; seen = 0;
    while (c < 100) begin
      if (done) begin seen = 1; break; end
      tick();
      c++;
    end
    check("same_cycle_done_seen", 32'(seen), 32'd1);
    check("same_cycle_latency", 32'(c), 32'd6);
    check("same_cycle_spins", 32'(spins), 32'b010);
    tick();

    // Reset asserted while sampling
    mode = 1;
    run_cycles = 16'd2; sample_cycles = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_reset_sampling", 32'({busy, core_rstn}), 32'b11);
    #2 rstn = 1'b0;
    #1;
    check("midrst_weights", 32'(weights), 32'd0);
    check("midrst_core_rstn", 32'(core_rstn), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_spins", 32'(spins), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("midrst_ready_after", 32'(wr_ready), 32'd1);
    check("midrst_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
